// File: rtl/uart_fifo_core.sv
// uart_fifo_core: UART transceiver with TX/RX FIFOs and receive error pulses.
// Line format: start(0), DATA_BITS data bits LSB first, optional parity, and
// STOP_BITS stop bits(1).
// Ports:
//   CLK, rst_n                 clock and synchronous active-low reset
//   RX / TX                    serial line in (asynchronous) / out (idle high)
//   tx_data/tx_valid/tx_ready  write side of the TX FIFO
//   rx_data/rx_valid/rx_ready  first-word fall-through read side of the RX FIFO
//   rx_err_frame/_parity       one-cycle pulses on a discarded bad character
//   rx_overrun                 one-cycle pulse when a good character is lost
//   tx_level/rx_level          FIFO occupancy
//   tx_busy                    transmitter active or TX FIFO not empty
module uart_fifo_core #(
  parameter int FCLK_HZ    = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          CLK,
  input  logic                          rst_n,
  input  logic                          RX,
  output logic                          TX,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_err_frame,
  output logic                          rx_err_parity,
  output logic                          rx_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          tx_busy
);

  localparam int DIV = (FCLK_HZ + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(DIV) + 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [LW-1:0] LVL_ZERO  = LW'(0);
  localparam logic [LW-1:0] LVL_ONE   = LW'(1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam bit            HAS_PAR   = (PARITY != 0);
  localparam bit            ODD_PAR   = (PARITY == 2);

  // Parity bit to transmit (or expect) for a character.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    parity_bit = ODD_PAR ? ~(^d) : (^d);
  endfunction

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT} rx_state_t;

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tx_mem_r [FIFO_DEPTH];
  logic [AW-1:0]        tx_wr_r, tx_rd_r;
  logic [LW-1:0]        tx_lvl_r;
  logic                 tx_push_s, tx_pop_s;

  assign tx_push_s = tx_valid && (tx_lvl_r != LVL_FULL);

  // TX FIFO pointers and occupancy counter.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      tx_wr_r  <= {AW{1'b0}};
      tx_rd_r  <= {AW{1'b0}};
      tx_lvl_r <= LVL_ZERO;
    end else begin
      if (tx_push_s) tx_wr_r <= tx_wr_r + PTR_ONE;
      if (tx_pop_s)  tx_rd_r <= tx_rd_r + PTR_ONE;
      case ({tx_push_s, tx_pop_s})
        2'b10:   tx_lvl_r <= tx_lvl_r + LVL_ONE;
        2'b01:   tx_lvl_r <= tx_lvl_r - LVL_ONE;
        default: tx_lvl_r <= tx_lvl_r;
      endcase
    end
  end

  // TX FIFO storage.
  always_ff @(posedge CLK) begin
    if (tx_push_s) tx_mem_r[tx_wr_r] <= tx_data;
  end

  // ---------------- Transmitter ----------------
  tx_state_t            tx_state_r, tx_state_nxt_s;
  logic [CW-1:0]        tx_cnt_r, tx_cnt_nxt_s;
  logic [3:0]           tx_idx_r, tx_idx_nxt_s;
  logic [DATA_BITS-1:0] tx_sh_r, tx_sh_nxt_s;
  logic                 tx_par_r, tx_par_nxt_s;
  logic                 tx_line_r, tx_line_s;
  logic                 tx_end_s;

  // Transmitter next state; a pop at the end of STOP starts the next frame with no gap.
  always_comb begin
    tx_state_nxt_s = tx_state_r;
    tx_cnt_nxt_s   = tx_cnt_r + CNT_ONE;
    tx_idx_nxt_s   = tx_idx_r;
    tx_sh_nxt_s    = tx_sh_r;
    tx_par_nxt_s   = tx_par_r;
    tx_pop_s       = 1'b0;
    tx_line_s      = 1'b1;
    tx_end_s       = (tx_cnt_r == DIV_LAST);
    if (tx_end_s) begin
      tx_cnt_nxt_s = CNT_ZERO;
    end else begin
      tx_cnt_nxt_s = tx_cnt_r + CNT_ONE;
    end
    case (tx_state_r)
      TX_IDLE: begin
        tx_cnt_nxt_s = CNT_ZERO;
        tx_pop_s     = (tx_lvl_r != LVL_ZERO);
      end
      TX_START: begin
        tx_line_s = 1'b0;
        if (tx_end_s) begin
          tx_state_nxt_s = TX_DATA;
          tx_idx_nxt_s   = 4'd0;
        end else begin
          tx_state_nxt_s = TX_START;
        end
      end
      TX_DATA: begin
        tx_line_s = tx_sh_r[0];
        if (tx_end_s) begin
          tx_sh_nxt_s = tx_sh_r >> 1;
          if (tx_idx_r == DATA_LAST) begin
            tx_idx_nxt_s   = 4'd0;
            tx_state_nxt_s = HAS_PAR ? TX_PAR : TX_STOP;
          end else begin
            tx_idx_nxt_s = tx_idx_r + 4'd1;
          end
        end else begin
          tx_state_nxt_s = TX_DATA;
        end
      end
      TX_PAR: begin
        tx_line_s = tx_par_r;
        if (tx_end_s) begin
          tx_state_nxt_s = TX_STOP;
          tx_idx_nxt_s   = 4'd0;
        end else begin
          tx_state_nxt_s = TX_PAR;
        end
      end
      TX_STOP: begin
        tx_line_s = 1'b1;
        if (tx_end_s && (tx_idx_r == STOP_LAST)) begin
          tx_pop_s       = (tx_lvl_r != LVL_ZERO);
          tx_state_nxt_s = TX_IDLE;
        end else if (tx_end_s) begin
          tx_idx_nxt_s = tx_idx_r + 4'd1;
        end else begin
          tx_state_nxt_s = TX_STOP;
        end
      end
      default: begin
        tx_state_nxt_s = TX_IDLE;
      end
    endcase
    if (tx_pop_s) begin
      tx_state_nxt_s = TX_START;
      tx_cnt_nxt_s   = CNT_ZERO;
      tx_idx_nxt_s   = 4'd0;
      tx_sh_nxt_s    = tx_mem_r[tx_rd_r];
      tx_par_nxt_s   = parity_bit(tx_mem_r[tx_rd_r]);
    end else begin
      tx_par_nxt_s = tx_par_nxt_s;
    end
  end

  // Transmitter registers; the line register follows the state one cycle later.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      tx_state_r <= TX_IDLE;
      tx_cnt_r   <= CNT_ZERO;
      tx_idx_r   <= 4'd0;
      tx_sh_r    <= {DATA_BITS{1'b0}};
      tx_par_r   <= 1'b0;
      tx_line_r  <= 1'b1;
    end else begin
      tx_state_r <= tx_state_nxt_s;
      tx_cnt_r   <= tx_cnt_nxt_s;
      tx_idx_r   <= tx_idx_nxt_s;
      tx_sh_r    <= tx_sh_nxt_s;
      tx_par_r   <= tx_par_nxt_s;
      tx_line_r  <= tx_line_s;
    end
  end

  assign TX       = tx_line_r;
  assign tx_ready = (tx_lvl_r != LVL_FULL);
  assign tx_level = tx_lvl_r;
  assign tx_busy  = (tx_state_r != TX_IDLE) || (tx_lvl_r != LVL_ZERO);

  // ---------------- Receiver ----------------
  logic                 rx_meta_r, rx_sync_r, rx_prev_r;
  rx_state_t            rx_state_r, rx_state_nxt_s;
  logic [CW-1:0]        rx_cnt_r, rx_cnt_nxt_s;
  logic [3:0]           rx_idx_r, rx_idx_nxt_s;
  logic [DATA_BITS-1:0] rx_sh_r, rx_sh_nxt_s;
  logic                 rx_perr_r, rx_perr_nxt_s;
  logic                 rx_ferr_r, rx_ferr_nxt_s;
  logic                 rx_done_r, rx_done_nxt_s;
  logic                 rx_smp_s;

  // Receiver next state; rx_done marks the cycle after the last stop sample.
  always_comb begin
    rx_state_nxt_s = rx_state_r;
    rx_cnt_nxt_s   = rx_cnt_r + CNT_ONE;
    rx_idx_nxt_s   = rx_idx_r;
    rx_sh_nxt_s    = rx_sh_r;
    rx_perr_nxt_s  = rx_perr_r;
    rx_ferr_nxt_s  = rx_ferr_r;
    rx_done_nxt_s  = 1'b0;
    rx_smp_s       = (rx_cnt_r == DIV_LAST);
    if (rx_smp_s) begin
      rx_cnt_nxt_s = CNT_ZERO;
    end else begin
      rx_cnt_nxt_s = rx_cnt_r + CNT_ONE;
    end
    case (rx_state_r)
      RX_IDLE: begin
        rx_cnt_nxt_s = CNT_ZERO;
        if (rx_prev_r && !rx_sync_r) begin
          rx_state_nxt_s = RX_START;
          rx_perr_nxt_s  = 1'b0;
          rx_ferr_nxt_s  = 1'b0;
        end else begin
          rx_state_nxt_s = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_r == HALF_LAST) begin
          rx_cnt_nxt_s   = CNT_ZERO;
          rx_idx_nxt_s   = 4'd0;
          rx_state_nxt_s = rx_sync_r ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_nxt_s = rx_cnt_r + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_smp_s) begin
          rx_sh_nxt_s = {rx_sync_r, rx_sh_r[DATA_BITS-1:1]};
          if (rx_idx_r == DATA_LAST) begin
            rx_idx_nxt_s   = 4'd0;
            rx_state_nxt_s = HAS_PAR ? RX_PAR : RX_STOP;
          end else begin
            rx_idx_nxt_s = rx_idx_r + 4'd1;
          end
        end else begin
          rx_state_nxt_s = RX_DATA;
        end
      end
      RX_PAR: begin
        if (rx_smp_s) begin
          rx_perr_nxt_s  = rx_sync_r ^ parity_bit(rx_sh_r);
          rx_idx_nxt_s   = 4'd0;
          rx_state_nxt_s = RX_STOP;
        end else begin
          rx_state_nxt_s = RX_PAR;
        end
      end
      RX_STOP: begin
        if (rx_smp_s) begin
          rx_ferr_nxt_s = rx_ferr_r | ~rx_sync_r;
          if (rx_idx_r == STOP_LAST) begin
            rx_done_nxt_s  = 1'b1;
            rx_state_nxt_s = rx_ferr_nxt_s ? RX_WAIT : RX_IDLE;
          end else begin
            rx_idx_nxt_s = rx_idx_r + 4'd1;
          end
        end else begin
          rx_state_nxt_s = RX_STOP;
        end
      end
      RX_WAIT: begin
        rx_cnt_nxt_s   = CNT_ZERO;
        rx_state_nxt_s = rx_sync_r ? RX_IDLE : RX_WAIT;
      end
      default: begin
        rx_state_nxt_s = RX_IDLE;
      end
    endcase
  end

  // Synchroniser, edge history and receiver registers.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      rx_meta_r  <= 1'b1;
      rx_sync_r  <= 1'b1;
      rx_prev_r  <= 1'b1;
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= CNT_ZERO;
      rx_idx_r   <= 4'd0;
      rx_sh_r    <= {DATA_BITS{1'b0}};
      rx_perr_r  <= 1'b0;
      rx_ferr_r  <= 1'b0;
      rx_done_r  <= 1'b0;
    end else begin
      rx_meta_r  <= RX;
      rx_sync_r  <= rx_meta_r;
      rx_prev_r  <= rx_sync_r;
      rx_state_r <= rx_state_nxt_s;
      rx_cnt_r   <= rx_cnt_nxt_s;
      rx_idx_r   <= rx_idx_nxt_s;
      rx_sh_r    <= rx_sh_nxt_s;
      rx_perr_r  <= rx_perr_nxt_s;
      rx_ferr_r  <= rx_ferr_nxt_s;
      rx_done_r  <= rx_done_nxt_s;
    end
  end

  // ---------------- RX FIFO and error pulses ----------------
  logic [DATA_BITS-1:0] rx_mem_r [FIFO_DEPTH];
  logic [AW-1:0]        rx_wr_r, rx_rd_r;
  logic [LW-1:0]        rx_lvl_r;
  logic                 rx_push_s, rx_pop_s, rx_good_s, rx_full_s;
  logic                 rx_fe_r, rx_pe_r, rx_ov_r;

  assign rx_full_s = (rx_lvl_r == LVL_FULL);
  assign rx_pop_s  = rx_ready && (rx_lvl_r != LVL_ZERO);
  assign rx_good_s = rx_done_r && !rx_perr_r && !rx_ferr_r;
  // A full FIFO still accepts the character when a pop frees a slot this cycle.
  assign rx_push_s = rx_good_s && (!rx_full_s || rx_pop_s);

  // RX FIFO pointers, occupancy and error pulse registers.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      rx_wr_r  <= {AW{1'b0}};
      rx_rd_r  <= {AW{1'b0}};
      rx_lvl_r <= LVL_ZERO;
      rx_fe_r  <= 1'b0;
      rx_pe_r  <= 1'b0;
      rx_ov_r  <= 1'b0;
    end else begin
      if (rx_push_s) rx_wr_r <= rx_wr_r + PTR_ONE;
      if (rx_pop_s)  rx_rd_r <= rx_rd_r + PTR_ONE;
      case ({rx_push_s, rx_pop_s})
        2'b10:   rx_lvl_r <= rx_lvl_r + LVL_ONE;
        2'b01:   rx_lvl_r <= rx_lvl_r - LVL_ONE;
        default: rx_lvl_r <= rx_lvl_r;
      endcase
      rx_fe_r <= rx_done_r && rx_ferr_r;
      rx_pe_r <= rx_done_r && rx_perr_r;
      rx_ov_r <= rx_good_s && rx_full_s && !rx_pop_s;
    end
  end

  // RX FIFO storage.
  always_ff @(posedge CLK) begin
    if (rx_push_s) rx_mem_r[rx_wr_r] <= rx_sh_r;
  end

  assign rx_data       = (rx_lvl_r != LVL_ZERO) ? rx_mem_r[rx_rd_r] : {DATA_BITS{1'b0}};
  assign rx_valid      = (rx_lvl_r != LVL_ZERO);
  assign rx_level      = rx_lvl_r;
  assign rx_err_frame  = rx_fe_r;
  assign rx_err_parity = rx_pe_r;
  assign rx_overrun    = rx_ov_r;

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core. Three instances share one clock/reset:
//   A: 8N1, DIV=16, depth 16, TX looped to RX
//   B: 7E2, DIV=16, depth 4,  TX looped to RX
//   C: 8O1, DIV=250, depth 4, RX driven by the bench
module tb_uart_fifo_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int n_asserts = 0;
  int n_fail    = 0;

  // Instance A
  logic       a_line, a_tx_valid, a_tx_ready, a_rx_valid, a_rx_ready;
  logic       a_fe, a_pe, a_ov, a_busy;
  logic [7:0] a_tx_data, a_rx_data;
  logic [4:0] a_tx_level, a_rx_level;
  uart_fifo_core #(.FCLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(16)) u_a (
    .CLK(clk), .rst_n(rst_n), .RX(a_line), .TX(a_line),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready),
    .rx_err_frame(a_fe), .rx_err_parity(a_pe), .rx_overrun(a_ov),
    .tx_level(a_tx_level), .rx_level(a_rx_level), .tx_busy(a_busy));

  // Instance B
  logic       b_line, b_tx_valid, b_tx_ready, b_rx_valid, b_rx_ready;
  logic       b_fe, b_pe, b_ov, b_busy;
  logic [6:0] b_tx_data, b_rx_data;
  logic [2:0] b_tx_level, b_rx_level;
  uart_fifo_core #(.FCLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(1),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
    .CLK(clk), .rst_n(rst_n), .RX(b_line), .TX(b_line),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
    .rx_err_frame(b_fe), .rx_err_parity(b_pe), .rx_overrun(b_ov),
    .tx_level(b_tx_level), .rx_level(b_rx_level), .tx_busy(b_busy));

  // Instance C
  logic       c_rx, c_tx, c_tx_valid, c_tx_ready, c_rx_valid, c_rx_ready;
  logic       c_fe, c_pe, c_ov, c_busy;
  logic [7:0] c_tx_data, c_rx_data;
  logic [2:0] c_tx_level, c_rx_level;
  uart_fifo_core #(.FCLK_HZ(25_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
    .CLK(clk), .rst_n(rst_n), .RX(c_rx), .TX(c_tx),
    .tx_data(c_tx_data), .tx_valid(c_tx_valid), .tx_ready(c_tx_ready),
    .rx_data(c_rx_data), .rx_valid(c_rx_valid), .rx_ready(c_rx_ready),
    .rx_err_frame(c_fe), .rx_err_parity(c_pe), .rx_overrun(c_ov),
    .tx_level(c_tx_level), .rx_level(c_rx_level), .tx_busy(c_busy));

  // Received characters, flag pulse counts and B's high-run lengths.
  logic [7:0] a_q[$];
  logic [6:0] b_q[$];
  int         b_runs[$];
  int a_nfe = 0, a_npe = 0, a_nov = 0;
  int b_nfl = 0, c_nfe = 0, c_npe = 0, c_nov = 0;
  int b_hi = 0;
  bit b_seen_low = 1'b0;

  always @(negedge clk) begin
    if (a_rx_valid && a_rx_ready) a_q.push_back(a_rx_data);
    if (b_rx_valid && b_rx_ready) b_q.push_back(b_rx_data);
    if (a_fe) a_nfe++;
    if (a_pe) a_npe++;
    if (a_ov) a_nov++;
    if (b_fe || b_pe || b_ov) b_nfl++;
    if (c_fe) c_nfe++;
    if (c_pe) c_npe++;
    if (c_ov) c_nov++;
    if (b_line) begin
      b_hi++;
    end else begin
      if (b_seen_low && b_hi > 0) b_runs.push_back(b_hi);
      b_hi = 0;
      b_seen_low = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [7:0] d);
    int t = 0;
    @(negedge clk);
    a_tx_data  = d;
    a_tx_valid = 1'b1;
    while (!a_tx_ready && t < 20000) begin @(negedge clk); t++; end
    if (t >= 20000) chk("send_a_timeout", 32'd0, 32'd1);
    @(negedge clk);
    a_tx_valid = 1'b0;
  endtask

  task automatic send_b(input logic [6:0] d);
    int t = 0;
    @(negedge clk);
    b_tx_data  = d;
    b_tx_valid = 1'b1;
    while (!b_tx_ready && t < 20000) begin @(negedge clk); t++; end
    if (t >= 20000) chk("send_b_timeout", 32'd0, 32'd1);
    @(negedge clk);
    b_tx_valid = 1'b0;
  endtask

  task automatic wait_a(input int n, input string tag);
    int t = 0;
    while (a_q.size() < n && t < 20000) begin @(negedge clk); t++; end
    chk(tag, 32'(a_q.size() >= n), 32'd1);
  endtask

  // One 8O1 frame at DIV=250 on C's RX; flip inverts the parity bit.
  task automatic drive_c(input logic [7:0] d, input bit flip);
    @(negedge clk);
    c_rx = 1'b0;
    repeat (250) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      c_rx = d[i];
      repeat (250) @(negedge clk);
    end
    c_rx = (~^d) ^ flip;
    repeat (250) @(negedge clk);
    c_rx = 1'b1;
    repeat (270) @(negedge clk);
  endtask

  task automatic pop_c();
    @(negedge clk);
    c_rx_ready = 1'b1;
    @(negedge clk);
    c_rx_ready = 1'b0;
  endtask

  logic [7:0] pkt [20];
  logic [7:0] sum;
  int base;
  int rbase;
  int t;

  initial begin
    rst_n = 1'b0;
    a_tx_valid = 1'b0; a_tx_data = 8'h00; a_rx_ready = 1'b1;
    b_tx_valid = 1'b0; b_tx_data = 7'h00; b_rx_ready = 1'b1;
    c_tx_valid = 1'b0; c_tx_data = 8'h00; c_rx_ready = 1'b0; c_rx = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx",       32'(a_line),     32'd1);
    chk("rst_tx_ready", 32'(a_tx_ready), 32'd1);
    chk("rst_rx_valid", 32'(a_rx_valid), 32'd0);
    chk("rst_rx_data",  32'(a_rx_data),  32'd0);
    chk("rst_tx_level", 32'(a_tx_level), 32'd0);
    chk("rst_rx_level", 32'(a_rx_level), 32'd0);
    chk("rst_flags",    32'({a_fe, a_pe, a_ov}), 32'd0);
    chk("rst_busy",     32'(a_busy),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // TX latency on 0xAA, then reset during data bit 3
    a_tx_data  = 8'hAA;
    a_tx_valid = 1'b1;
    @(posedge clk); #1;
    a_tx_valid = 1'b0;
    chk("tx_level_inc", 32'(a_tx_level), 32'd1);
    chk("tx_high_N",    32'(a_line),     32'd1);
    @(posedge clk); #1;
    chk("tx_high_N1",   32'(a_line),     32'd1);
    @(posedge clk); #1;
    chk("tx_fall_N2",   32'(a_line),     32'd0);
    repeat (72) @(posedge clk);
    #1;
    chk("tx_bit3_of_AA", 32'(a_line), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_tx",       32'(a_line),     32'd1);
    chk("midrst_tx_level", 32'(a_tx_level), 32'd0);
    chk("midrst_rx_level", 32'(a_rx_level), 32'd0);
    chk("midrst_busy",     32'(a_busy),     32'd0);
    rst_n = 1'b1;
    base = a_q.size();
    send_a(8'h5A);
    wait_a(base + 1, "after_rst_wait");
    chk("after_rst_data", 32'(a_q[base]), 32'h5A);

    // Packet AA 01 10 + 0x10..0x1F + 8-bit sum, popped continuously
    pkt[0] = 8'hAA; pkt[1] = 8'h01; pkt[2] = 8'h10;
    for (int i = 0; i < 16; i++) pkt[3 + i] = 8'(8'h10 + i);
    sum = 8'h00;
    for (int i = 0; i < 19; i++) sum = sum + pkt[i];
    pkt[19] = sum;
    base = a_q.size();
    for (int i = 0; i < 20; i++) send_a(pkt[i]);
    wait_a(base + 20, "pkt_wait");
    for (int i = 0; i < 20; i++) chk("pkt_byte", 32'(a_q[base + i]), 32'(pkt[i]));
    chk("pkt_flags", 32'(a_nfe + a_npe + a_nov), 32'd0);

    // Overrun: 17 characters into a 16-deep RX FIFO that is not popped
    @(posedge clk); #1;
    a_rx_ready = 1'b0;
    for (int i = 0; i <= 16; i++) send_a(8'(i));
    t = 0;
    while (a_busy && t < 20000) begin @(negedge clk); t++; end
    chk("ovr_tx_done", 32'(t < 20000), 32'd1);
    repeat (60) @(negedge clk);
    chk("ovr_level", 32'(a_rx_level), 32'd16);
    chk("ovr_pulse", 32'(a_nov),      32'd1);
    base = a_q.size();
    @(posedge clk); #1;
    a_rx_ready = 1'b1;
    wait_a(base + 16, "ovr_pop_wait");
    for (int i = 0; i < 16; i++) chk("ovr_byte", 32'(a_q[base + i]), 32'(i));
    repeat (5) @(negedge clk);
    chk("ovr_level_empty", 32'(a_rx_level), 32'd0);

    // 7E2 loopback with back-to-back characters
    rbase = b_runs.size();
    send_b(7'h00);
    send_b(7'h7F);
    send_b(7'h55);
    t = 0;
    while (b_q.size() < 3 && t < 20000) begin @(negedge clk); t++; end
    chk("b_wait", 32'(b_q.size() >= 3), 32'd1);
    chk("b_byte0", 32'(b_q[0]), 32'h00);
    chk("b_byte1", 32'(b_q[1]), 32'h7F);
    chk("b_byte2", 32'(b_q[2]), 32'h55);
    chk("b_gap_stop_only", 32'(b_runs[rbase]),     32'd32);
    chk("b_gap_after_7F",  32'(b_runs[rbase + 1]), 32'd160);
    chk("b_flags", 32'(b_nfl), 32'd0);

    // C: flipped parity on 0x3C, then a good 0x3C
    drive_c(8'h3C, 1'b1);
    chk("par_pulse", 32'(c_npe),      32'd1);
    chk("par_nofe",  32'(c_nfe),      32'd0);
    chk("par_level", 32'(c_rx_level), 32'd0);
    drive_c(8'h3C, 1'b0);
    chk("good3C_level", 32'(c_rx_level), 32'd1);
    chk("good3C_data",  32'(c_rx_data),  32'h3C);
    chk("good3C_npe",   32'(c_npe),      32'd1);
    pop_c();
    chk("good3C_popped", 32'(c_rx_level), 32'd0);

    // Break: 12 bit times low (all-zero data with a 0 parity bit also fails odd parity)
    @(negedge clk);
    c_rx = 1'b0;
    repeat (3000) @(negedge clk);
    c_rx = 1'b1;
    repeat (500) @(negedge clk);
    chk("brk_fe",    32'(c_nfe),      32'd1);
    chk("brk_pe",    32'(c_npe),      32'd2);
    chk("brk_level", 32'(c_rx_level), 32'd0);
    drive_c(8'hA5, 1'b0);
    chk("postbrk_level", 32'(c_rx_level), 32'd1);
    chk("postbrk_data",  32'(c_rx_data),  32'hA5);
    pop_c();

    // 100-cycle low glitch
    @(negedge clk);
    c_rx = 1'b0;
    repeat (100) @(negedge clk);
    c_rx = 1'b1;
    repeat (3000) @(negedge clk);
    chk("glitch_level", 32'(c_rx_level), 32'd0);
    chk("glitch_fe",    32'(c_nfe),      32'd1);
    chk("glitch_pe",    32'(c_npe),      32'd2);
    chk("c_overrun",    32'(c_nov),      32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
